// File: rtl/move_objeto.sv
// Position controller for the movable square: samples keys and collision flags
// once per movement tick and steps xPos/yPos by PASSO, clamped to 640x480.
module move_objeto #(
  parameter int unsigned X_INI   = 110,
  parameter int unsigned Y_INI   = 120,
  parameter int unsigned PASSO   = 2,
  parameter int unsigned DIV     = 416666,
  parameter int unsigned TAMANHO = 20
) (
  input  logic       VGA_clk,
  input  logic       rst_n,
  input  logic       tecla_esq,
  input  logic       tecla_dir,
  input  logic       tecla_cima,
  input  logic       tecla_baixo,
  input  logic       colisao_min_x,
  input  logic       colisao_max_x,
  input  logic       colisao_min_y,
  input  logic       colisao_max_y,
  output logic [9:0] xPos,
  output logic [8:0] yPos,
  output logic [6:0] tamanho,
  output logic       movendo,
  output logic       bloqueado
);

  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned T_W   = 7;
  localparam int unsigned A_W   = 11;
  localparam int unsigned DIV_W = $clog2(DIV);
  localparam int unsigned X_MAX = 640 - TAMANHO;
  localparam int unsigned Y_MAX = 480 - TAMANHO;

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    AMOSTRA  = 2'd1,
    ATUALIZA = 2'd2,
    ASSENTA  = 2'd3
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             assenta_q, assenta_d;
  logic [3:0]       teclas_q, teclas_d;
  logic [3:0]       flags_q, flags_d;
  logic [X_W-1:0]   x_d;
  logic [Y_W-1:0]   y_d;
  logic             mov_d, blk_d;
  logic             tick;

  // Latched copies: teclas = {esq, dir, cima, baixo}, flags = {min_x, max_x, min_y, max_y}
  logic esq_q, dir_q, cima_q, baixo_q;
  logic fmin_x_q, fmax_x_q, fmin_y_q, fmax_y_q;
  assign {esq_q, dir_q, cima_q, baixo_q}       = teclas_q;
  assign {fmin_x_q, fmax_x_q, fmin_y_q, fmax_y_q} = flags_q;

  assign tick    = (div_q == DIV_W'(DIV - 1));
  assign tamanho = T_W'(TAMANHO);

  // Saturating candidate positions, 11-bit so the sum never wraps
  logic [A_W-1:0] x_cur, y_cur, x_sub, y_sub, x_add, y_add, x_sat, y_sat;
  assign x_cur = A_W'(xPos);
  assign y_cur = A_W'(yPos);
  assign x_sub = (x_cur >= A_W'(PASSO)) ? (x_cur - A_W'(PASSO)) : '0;
  assign y_sub = (y_cur >= A_W'(PASSO)) ? (y_cur - A_W'(PASSO)) : '0;
  assign x_add = x_cur + A_W'(PASSO);
  assign y_add = y_cur + A_W'(PASSO);
  assign x_sat = (x_add > A_W'(X_MAX)) ? A_W'(X_MAX) : x_add;
  assign y_sat = (y_add > A_W'(Y_MAX)) ? A_W'(Y_MAX) : y_add;

  logic           req_esq, req_dir, req_cima, req_baixo;
  logic           blk_x, blk_y;
  logic [X_W-1:0] x_nova;
  logic [Y_W-1:0] y_nova;

  assign req_esq   = esq_q & ~dir_q;
  assign req_dir   = dir_q & ~esq_q;
  assign req_cima  = cima_q & ~baixo_q;
  assign req_baixo = baixo_q & ~cima_q;

  // Per-axis move resolution; a refused request keeps the position
  always_comb begin
    x_nova = xPos;
    y_nova = yPos;
    blk_x  = 1'b0;
    blk_y  = 1'b0;
    if (req_esq) begin
      if (fmin_x_q) blk_x  = 1'b1;
      else          x_nova = X_W'(x_sub);
    end else if (req_dir) begin
      if (fmax_x_q) blk_x  = 1'b1;
      else          x_nova = X_W'(x_sat);
    end
    if (req_cima) begin
      if (fmin_y_q) blk_y  = 1'b1;
      else          y_nova = Y_W'(y_sub);
    end else if (req_baixo) begin
      if (fmax_y_q) blk_y  = 1'b1;
      else          y_nova = Y_W'(y_sat);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    estado_d  = estado_q;
    div_d     = tick ? '0 : (div_q + DIV_W'(1));
    assenta_d = assenta_q;
    teclas_d  = teclas_q;
    flags_d   = flags_q;
    x_d       = xPos;
    y_d       = yPos;
    mov_d     = 1'b0;
    blk_d     = 1'b0;
    case (estado_q)
      ESPERA: begin
        if (tick) estado_d = AMOSTRA;
      end
      AMOSTRA: begin
        teclas_d = {tecla_esq, tecla_dir, tecla_cima, tecla_baixo};
        flags_d  = {colisao_min_x, colisao_max_x, colisao_min_y, colisao_max_y};
        estado_d = ATUALIZA;
      end
      ATUALIZA: begin
        x_d       = x_nova;
        y_d       = y_nova;
        mov_d     = (x_nova != xPos) || (y_nova != yPos);
        blk_d     = blk_x | blk_y;
        assenta_d = 1'b0;
        estado_d  = ASSENTA;
      end
      ASSENTA: begin
        // Two settle cycles for the negedge collision stage
        assenta_d = 1'b1;
        if (assenta_q) estado_d = ESPERA;
      end
      default: estado_d = ESPERA;
    endcase
  end

  always_ff @(posedge VGA_clk) begin
    if (!rst_n) begin
      estado_q  <= ESPERA;
      div_q     <= '0;
      assenta_q <= 1'b0;
      teclas_q  <= '0;
      flags_q   <= '0;
      xPos      <= X_W'(X_INI);
      yPos      <= Y_W'(Y_INI);
      movendo   <= 1'b0;
      bloqueado <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      div_q     <= div_d;
      assenta_q <= assenta_d;
      teclas_q  <= teclas_d;
      flags_q   <= flags_d;
      xPos      <= x_d;
      yPos      <= y_d;
      movendo   <= mov_d;
      bloqueado <= blk_d;
    end
  end

endmodule

// File: tb/tb_move_objeto.sv
// Self-checking bench for move_objeto: two instances (mid-screen and corner start)
// share stimulus and are compared against an integer reference model per tick.
module tb_move_objeto;

  localparam int unsigned DIV   = 8;
  localparam int unsigned PASSO = 2;
  localparam int unsigned TAM   = 20;
  localparam int XA0 = 110, YA0 = 120, XB0 = 619, YB0 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic esq = 0, dir = 0, cima = 0, baixo = 0;
  logic cmin_x = 0, cmax_x = 0, cmin_y = 0, cmax_y = 0;
  logic [9:0] xa, xb;
  logic [8:0] ya, yb;
  logic [6:0] ta, tb_t;
  logic mova, blka, movb, blkb;

  int checks = 0;
  int errors = 0;
  int mxa, mya, mxb, myb;
  int edges_left;

  move_objeto #(.X_INI(XA0), .Y_INI(YA0), .PASSO(PASSO), .DIV(DIV), .TAMANHO(TAM)) dut_a (
    .VGA_clk(clk), .rst_n(rst_n),
    .tecla_esq(esq), .tecla_dir(dir), .tecla_cima(cima), .tecla_baixo(baixo),
    .colisao_min_x(cmin_x), .colisao_max_x(cmax_x), .colisao_min_y(cmin_y), .colisao_max_y(cmax_y),
    .xPos(xa), .yPos(ya), .tamanho(ta), .movendo(mova), .bloqueado(blka)
  );

  move_objeto #(.X_INI(XB0), .Y_INI(YB0), .PASSO(PASSO), .DIV(DIV), .TAMANHO(TAM)) dut_b (
    .VGA_clk(clk), .rst_n(rst_n),
    .tecla_esq(esq), .tecla_dir(dir), .tecla_cima(cima), .tecla_baixo(baixo),
    .colisao_min_x(cmin_x), .colisao_max_x(cmax_x), .colisao_min_y(cmin_y), .colisao_max_y(cmax_y),
    .xPos(xb), .yPos(yb), .tamanho(tb_t), .movendo(movb), .bloqueado(blkb)
  );

  // One axis of the rules: opposite keys cancel, a flagged request is refused
  function automatic void model_axis(input int p, input bit neg, input bit pos,
                                     input bit fneg, input bit fpos, input int pmax,
                                     output int np, output bit blk);
    np  = p;
    blk = 1'b0;
    if (neg && !pos) begin
      if (fneg) blk = 1'b1;
      else np = (p - int'(PASSO) < 0) ? 0 : p - int'(PASSO);
    end else if (pos && !neg) begin
      if (fpos) blk = 1'b1;
      else np = (p + int'(PASSO) > pmax) ? pmax : p + int'(PASSO);
    end
  endfunction

  task automatic set_in(input logic [3:0] k, input logic [3:0] f);
    {esq, dir, cima, baixo}         = k;
    {cmin_x, cmax_x, cmin_y, cmax_y} = f;
  endtask

  task automatic test_reset(input string nome);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({xa, ya, mova, blka} !== {10'(XA0), 9'(YA0), 2'b00}) begin
      errors++;
      $display("FAIL %s_a: got x=%0d y=%0d mov=%b blk=%b, want x=%0d y=%0d 0 0", nome, xa, ya, mova, blka, XA0, YA0);
    end
    checks++;
    if ({xb, yb, movb, blkb} !== {10'(XB0), 9'(YB0), 2'b00}) begin
      errors++;
      $display("FAIL %s_b: got x=%0d y=%0d mov=%b blk=%b, want x=%0d y=%0d 0 0", nome, xb, yb, movb, blkb, XB0, YB0);
    end
    checks++;
    if (ta !== 7'(TAM)) begin
      errors++;
      $display("FAIL %s_tamanho: got %0d want %0d", nome, ta, TAM);
    end
    rst_n = 1'b1;
    mxa = XA0; mya = YA0; mxb = XB0; myb = YB0;
    edges_left = DIV + 2;
  endtask

  // Run to the next position update and compare both instances with the model
  task automatic tick_check(input string nome);
    int nxa, nya, nxb, nyb;
    bit bxa, bya, bxb, byb;
    logic [20:0] expa, expb;
    model_axis(mxa, esq, dir, cmin_x, cmax_x, 640 - int'(TAM), nxa, bxa);
    model_axis(mya, cima, baixo, cmin_y, cmax_y, 480 - int'(TAM), nya, bya);
    model_axis(mxb, esq, dir, cmin_x, cmax_x, 640 - int'(TAM), nxb, bxb);
    model_axis(myb, cima, baixo, cmin_y, cmax_y, 480 - int'(TAM), nyb, byb);
    repeat (edges_left - 1) @(posedge clk);
    #1;
    checks++;
    if ({xa, ya, mova, blka, xb, yb, movb, blkb} !== {10'(mxa), 9'(mya), 2'b00, 10'(mxb), 9'(myb), 2'b00}) begin
      errors++;
      $display("FAIL %s_early: got a=%0d,%0d,%b%b b=%0d,%0d,%b%b want a=%0d,%0d,00 b=%0d,%0d,00",
               nome, xa, ya, mova, blka, xb, yb, movb, blkb, mxa, mya, mxb, myb);
    end
    @(posedge clk); #1;
    expa = {10'(nxa), 9'(nya), (nxa != mxa) || (nya != mya), bxa | bya};
    expb = {10'(nxb), 9'(nyb), (nxb != mxb) || (nyb != myb), bxb | byb};
    checks++;
    if ({xa, ya, mova, blka} !== expa) begin
      errors++;
      $display("FAIL %s_a: got x=%0d y=%0d mov=%b blk=%b want x=%0d y=%0d mov=%b blk=%b",
               nome, xa, ya, mova, blka, expa[20:11], expa[10:2], expa[1], expa[0]);
    end
    checks++;
    if ({xb, yb, movb, blkb} !== expb) begin
      errors++;
      $display("FAIL %s_b: got x=%0d y=%0d mov=%b blk=%b want x=%0d y=%0d mov=%b blk=%b",
               nome, xb, yb, movb, blkb, expb[20:11], expb[10:2], expb[1], expb[0]);
    end
    @(posedge clk); #1;
    checks++;
    if ({mova, blka, movb, blkb} !== 4'b0000) begin
      errors++;
      $display("FAIL %s_pulse_end: got mova=%b blka=%b movb=%b blkb=%b want 0000", nome, mova, blka, movb, blkb);
    end
    mxa = nxa; mya = nya; mxb = nxb; myb = nyb;
    edges_left = DIV - 1;
  endtask

  task automatic test_right;
    test_reset("reset_right");
    set_in(4'b0100, 4'b0000);
    for (int i = 0; i < 3; i++) tick_check($sformatf("right%0d", i));
  endtask

  task automatic test_blocked_left;
    set_in(4'b1000, 4'b1000);
    for (int i = 0; i < 2; i++) tick_check($sformatf("left_blocked%0d", i));
  endtask

  task automatic test_both_x;
    set_in(4'b1100, 4'b0000);
    tick_check("both_x");
    set_in(4'b1101, 4'b0000);
    tick_check("both_x_down");
  endtask

  task automatic test_clamp;
    test_reset("reset_clamp");
    set_in(4'b0110, 4'b0000);
    for (int i = 0; i < 3; i++) tick_check($sformatf("clamp%0d", i));
  endtask

  task automatic test_diag_block;
    test_reset("reset_diag");
    set_in(4'b0101, 4'b0001);
    tick_check("diag_block");
  endtask

  task automatic test_reset_assenta;
    test_reset("reset_pre_assenta");
    set_in(4'b0100, 4'b0000);
    tick_check("assenta_move");
    test_reset("reset_in_assenta");
    tick_check("after_release");
  endtask

  task automatic test_random;
    test_reset("reset_random");
    for (int i = 0; i < 24; i++) begin
      set_in(4'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000);
      tick_check($sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_right();
    test_blocked_left();
    test_both_x();
    test_clamp();
    test_diag_block();
    test_reset_assenta();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
